// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared state encoding, default width and counter-width helper
//               for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int C_DEFAULT_WIDTH = 8;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_add_cell.sv
`default_nettype none
// ============================================================================
// Module      : half_add_cell
// Description : Single-bit half adder (sum = a ^ b, carry = a & b).
// Revision    : 1.0 - initial release
// ============================================================================
module half_add_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule
`default_nettype wire

// File: rtl/serial_add_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_unit
// Description : Bit-serial adder. Accepts LSB-first operand bit pairs over a
//               valid/ready handshake, chains the carry across cycles and
//               publishes a WIDTH-bit sum plus carry-out with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             done,
    output logic             busy
);

    localparam int                     CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]       C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shreg;

    logic               w_accept;
    logic               w_last;
    logic               w_p;
    logic               w_g;
    logic               w_sum;
    logic               w_pc;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_shreg_next;

    // Full adder built from two half-add cells plus an OR on the carries.
    half_add_cell u_ha_ab (
        .a (a_bit),
        .b (b_bit),
        .s (w_p),
        .c (w_g)
    );

    half_add_cell u_ha_pc (
        .a (w_p),
        .b (r_carry),
        .s (w_sum),
        .c (w_pc)
    );

    assign w_carry_next = w_g | w_pc;
    assign w_shreg_next = {w_sum, r_shreg[WIDTH-1:1]};
    assign w_accept     = (r_state == SHIFT) && in_valid;
    assign w_last       = (r_cnt == C_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/status decode; outputs depend on state only.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                busy         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: clear on start, shift/accumulate on accept, publish on last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_carry <= 1'b0;
                r_cnt   <= '0;
                r_shreg <= '0;
            end
            if (w_accept) begin
                r_shreg <= w_shreg_next;
                r_carry <= w_carry_next;
                if (w_last) begin
                    sum_out   <= w_shreg_next;
                    carry_out <= w_carry_next;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
